// File: rtl/io_frontend_pkg.sv
// rtl/io_frontend_pkg.sv - shared LA map constants, pad defaults and input indices for io_frontend_unit
package io_frontend_pkg;

    localparam int LA_WIDTH              = 128;
    localparam int LA_OEB_BASE_DEFAULT   = 0;
    localparam int LA_DATA_BASE_DEFAULT  = 32;

    localparam logic IN_OEB_DEFAULT  = 1'b1;
    localparam logic OUT_OEB_DEFAULT = 1'b0;
    localparam logic DRV_OEB_DEFAULT = 1'b0;

    typedef enum int unsigned {
        IN_RESET_N         = 0,
        IN_LATCH_DATA      = 1,
        IN_CONTROL_TRIGGER = 2,
        IN_SCLK            = 3,
        IN_MOSI            = 4,
        IN_SS_N            = 5
    } in_idx_e;

    function automatic bit la_range_ok(input int base, input int count);
        return (base >= 0) && (base + count <= LA_WIDTH);
    endfunction

endpackage

// File: rtl/input_filter_channel.sv
// rtl/input_filter_channel.sv - one pad input: synchronizer, consecutive-sample filter, edge pulses
module input_filter_channel #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 3,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    // Any sample matching the current level restarts the run of differing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = sample;
                rise_d  = sample;
                fall_d  = ~sample;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            cnt_q   <= '0;
            level_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/io_frontend_unit.sv
// rtl/io_frontend_unit.sv - pad front end: LA overrides, pad enables, filtered inputs, stretched system reset
module io_frontend_unit
    import io_frontend_pkg::*;
#(
    parameter int              NUM_OF_DRIVERS  = 10,
    parameter int              NUM_IN          = 6,
    parameter int              NUM_OUT         = 2,
    parameter int              SYNC_STAGES     = 2,
    parameter int              FILTER_LEN      = 3,
    parameter int              RESET_STRETCH   = 16,
    parameter logic [NUM_IN-1:0] INPUT_RESET_VAL = 6'b000001,
    parameter int              LA_OEB_BASE     = LA_OEB_BASE_DEFAULT,
    parameter int              LA_DATA_BASE    = LA_DATA_BASE_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [127:0]              la_data_in,
    input  logic [127:0]              la_oenb,
    input  logic [NUM_IN-1:0]         io_in,
    output logic [NUM_IN-1:0]         io_in_oeb,
    input  logic [NUM_OUT-1:0]        stat_in,
    output logic [NUM_OUT-1:0]        io_out,
    output logic [NUM_OUT-1:0]        io_out_oeb,
    output logic [NUM_OF_DRIVERS-1:0] io_driver_oeb,
    output logic [NUM_IN-1:0]         in_level,
    output logic [NUM_IN-1:0]         in_rise,
    output logic [NUM_IN-1:0]         in_fall,
    output logic                      sys_reset_n
);

    localparam int OEB_IN   = LA_OEB_BASE;
    localparam int OEB_OUT  = LA_OEB_BASE + NUM_IN;
    localparam int OEB_DRV  = LA_OEB_BASE + NUM_IN + NUM_OUT;
    localparam int DAT_IN   = LA_DATA_BASE;
    localparam int DAT_OUT  = LA_DATA_BASE + NUM_IN;
    localparam int SW       = (RESET_STRETCH > 0) ? $clog2(RESET_STRETCH + 1) : 1;

    if (!la_range_ok(LA_OEB_BASE, NUM_IN + NUM_OUT + NUM_OF_DRIVERS) ||
        !la_range_ok(LA_DATA_BASE, NUM_IN + NUM_OUT)) begin : g_bad_la_map
        $error("io_frontend_unit: LA index map exceeds 128 bits");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("io_frontend_unit: SYNC_STAGES must be 2..4");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter
        $error("io_frontend_unit: FILTER_LEN must be 1..15");
    end

    logic [NUM_IN-1:0]         in_oeb_q, in_oeb_d;
    logic [NUM_OUT-1:0]        out_oeb_q, out_oeb_d;
    logic [NUM_OF_DRIVERS-1:0] drv_oeb_q, drv_oeb_d;
    logic [NUM_OUT-1:0]        out_q, out_d;
    logic [SW-1:0]             stretch_cnt_q;
    logic                      stretch_done_q;
    logic                      unused_la;

    assign unused_la = ^{la_data_in, la_oenb};

    always_comb begin
        in_oeb_d  = '0;
        out_oeb_d = '0;
        drv_oeb_d = '0;
        out_d     = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_oeb_d[i] = la_oenb[OEB_IN + i] ? IN_OEB_DEFAULT : la_data_in[OEB_IN + i];
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            out_oeb_d[k] = la_oenb[OEB_OUT + k] ? OUT_OEB_DEFAULT : la_data_in[OEB_OUT + k];
            out_d[k]     = la_oenb[DAT_OUT + k] ? stat_in[k] : la_data_in[DAT_OUT + k];
        end
        for (int d = 0; d < NUM_OF_DRIVERS; d++) begin
            drv_oeb_d[d] = la_oenb[OEB_DRV + d] ? DRV_OEB_DEFAULT : la_data_in[OEB_DRV + d];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_oeb_q  <= '1;
            out_oeb_q <= '0;
            drv_oeb_q <= '0;
            out_q     <= '0;
        end else begin
            in_oeb_q  <= in_oeb_d;
            out_oeb_q <= out_oeb_d;
            drv_oeb_q <= drv_oeb_d;
            out_q     <= out_d;
        end
    end

    assign io_in_oeb     = in_oeb_q;
    assign io_out_oeb    = out_oeb_q;
    assign io_driver_oeb = drv_oeb_q;
    assign io_out        = out_q;

    // The override mux sits ahead of the synchronizer so LA takeover edges are filtered too.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
        logic raw;
        assign raw = la_oenb[DAT_IN + gi] ? io_in[gi] : la_data_in[DAT_IN + gi];

        input_filter_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .RESET_VAL   (INPUT_RESET_VAL[gi])
        ) u_chan (
            .clk_i   (clock),
            .rst_ni  (reset_n),
            .raw_i   (raw),
            .level_o (in_level[gi]),
            .rise_o  (in_rise[gi]),
            .fall_o  (in_fall[gi])
        );
    end

    // Stretch counts down only while the soft-reset input is high; any low level reloads it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stretch_cnt_q  <= SW'(RESET_STRETCH);
            stretch_done_q <= 1'b0;
        end else if (!in_level[IN_RESET_N]) begin
            stretch_cnt_q  <= SW'(RESET_STRETCH);
            stretch_done_q <= 1'b0;
        end else begin
            if (stretch_cnt_q != '0) begin
                stretch_cnt_q <= stretch_cnt_q - SW'(1);
            end
            stretch_done_q <= (stretch_cnt_q <= SW'(1));
        end
    end

    assign sys_reset_n = stretch_done_q & in_level[IN_RESET_N];

endmodule

// File: tb/tb_io_frontend_unit.sv
// tb/tb_io_frontend_unit.sv - self-checking bench for io_frontend_unit against a behavioural model
module tb_io_frontend_unit;

    localparam int S       = 2;
    localparam int F       = 3;
    localparam int STRETCH = 16;
    localparam logic [5:0] RST_LVL = 6'b000001;

    logic         clock;
    logic         reset_n;
    logic [127:0] la_data_in;
    logic [127:0] la_oenb;
    logic [5:0]   io_in;
    logic [5:0]   io_in_oeb;
    logic [1:0]   stat_in;
    logic [1:0]   io_out;
    logic [1:0]   io_out_oeb;
    logic [9:0]   io_driver_oeb;
    logic [5:0]   in_level;
    logic [5:0]   in_rise;
    logic [5:0]   in_fall;
    logic         sys_reset_n;

    io_frontend_unit dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .la_data_in    (la_data_in),
        .la_oenb       (la_oenb),
        .io_in         (io_in),
        .io_in_oeb     (io_in_oeb),
        .stat_in       (stat_in),
        .io_out        (io_out),
        .io_out_oeb    (io_out_oeb),
        .io_driver_oeb (io_driver_oeb),
        .in_level      (in_level),
        .in_rise       (in_rise),
        .in_fall       (in_fall),
        .sys_reset_n   (sys_reset_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic [5:0] m_hist[$];
    logic [5:0] m_level;
    int         m_run[6];
    int         m_since;
    logic [5:0] e_rise, e_fall, e_in_oeb;
    logic [1:0] e_out_oeb, e_out;
    logic [9:0] e_drv_oeb;
    logic       e_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = {};
        for (int j = 0; j < S; j++) m_hist.push_back(RST_LVL);
        m_level   = RST_LVL;
        for (int i = 0; i < 6; i++) m_run[i] = 0;
        m_since   = 0;
        e_rise    = '0;
        e_fall    = '0;
        e_in_oeb  = '1;
        e_out_oeb = '0;
        e_drv_oeb = '0;
        e_out     = '0;
        e_sys     = 1'b0;
    endtask

    // One clock edge of the specified behaviour, given the inputs present at that edge.
    task automatic model_edge(input logic [5:0] raw, input logic [127:0] oenb,
                              input logic [127:0] dat, input logic [1:0] stat);
        logic [5:0] sample;
        logic       old0;
        sample = m_hist.pop_front();
        m_hist.push_back(raw);
        old0   = m_level[0];
        e_rise = '0;
        e_fall = '0;
        for (int i = 0; i < 6; i++) begin
            if (sample[i] == m_level[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] == F) begin
                    m_level[i] = ~m_level[i];
                    m_run[i]   = 0;
                    if (m_level[i]) e_rise[i] = 1'b1;
                    else            e_fall[i] = 1'b1;
                end
            end
        end
        if (old0) begin
            if (m_since < 1000) m_since++;
        end else begin
            m_since = 0;
        end
        e_sys = m_level[0] && (m_since >= STRETCH);
        for (int i = 0; i < 6; i++)  e_in_oeb[i]  = oenb[i] ? 1'b1 : dat[i];
        for (int k = 0; k < 2; k++)  e_out_oeb[k] = oenb[6+k] ? 1'b0 : dat[6+k];
        for (int d = 0; d < 10; d++) e_drv_oeb[d] = oenb[8+d] ? 1'b0 : dat[8+d];
        for (int k = 0; k < 2; k++)  e_out[k]     = oenb[38+k] ? stat[k] : dat[38+k];
    endtask

    task automatic compare_all();
        check("in_level",   32'(in_level),      32'(m_level));
        check("in_rise",    32'(in_rise),       32'(e_rise));
        check("in_fall",    32'(in_fall),       32'(e_fall));
        check("io_in_oeb",  32'(io_in_oeb),     32'(e_in_oeb));
        check("io_out_oeb", 32'(io_out_oeb),    32'(e_out_oeb));
        check("io_drv_oeb", 32'(io_driver_oeb), 32'(e_drv_oeb));
        check("io_out",     32'(io_out),        32'(e_out));
        check("sys_reset",  32'(sys_reset_n),   32'(e_sys));
    endtask

    task automatic tick();
        logic [5:0]   raw;
        logic [127:0] oenb, dat;
        logic [1:0]   stat;
        for (int i = 0; i < 6; i++) raw[i] = la_oenb[32+i] ? io_in[i] : la_data_in[32+i];
        oenb = la_oenb;
        dat  = la_data_in;
        stat = stat_in;
        @(posedge clock);
        model_edge(raw, oenb, dat, stat);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_level",  32'(in_level),      32'h01);
        check("rst_edges",  32'({in_rise, in_fall}), 32'h0);
        check("rst_in_oeb", 32'(io_in_oeb),     32'h3F);
        check("rst_outoeb", 32'(io_out_oeb),    32'h0);
        check("rst_drvoeb", 32'(io_driver_oeb), 32'h0);
        check("rst_io_out", 32'(io_out),        32'h0);
        check("rst_sys",    32'(sys_reset_n),   32'h0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_hold_level", 32'(in_level),    32'h01);
        check("rst_hold_sys",   32'(sys_reset_n), 32'h0);
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        int hold;
        reset_n    = 1'b1;
        la_data_in = '0;
        la_oenb    = '1;
        io_in      = 6'b000001;
        stat_in    = 2'b00;
        #2;
        do_reset();

        for (int c = 1; c <= 18; c++) begin
            tick();
            check("rst_stretch", 32'(sys_reset_n), 32'(c >= STRETCH));
        end

        stat_in = 2'b10;
        io_in[1] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("step_level", 32'(in_level[1]), 32'(c >= 5));
            check("step_rise",  32'(in_rise[1]),  32'(c == 5));
        end

        io_in[2] = 1'b1;
        tick();
        tick();
        io_in[2] = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("glitch2_level", 32'(in_level[2]), 32'h0);
            check("glitch2_edges", 32'({in_rise[2], in_fall[2]}), 32'h0);
        end
        for (int c = 1; c <= 10; c++) begin
            io_in[2] = (c <= 3);
            tick();
            check("glitch3_level", 32'(in_level[2]), 32'(c >= 5 && c < 8));
        end

        io_in[1] = 1'b0;
        repeat (8) tick();
        la_oenb[33]    = 1'b0;
        la_data_in[33] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("la_ovr_level", 32'(in_level[1]), 32'(c >= 5));
        end
        la_oenb[33] = 1'b1;
        la_oenb[7]    = 1'b0;
        la_data_in[7] = 1'b1;
        tick();
        check("la_out_oeb", 32'(io_out_oeb[1]), 32'h1);
        la_oenb[7] = 1'b1;
        repeat (8) tick();

        for (int c = 1; c <= 40; c++) begin
            io_in[0] = !((c <= 4) || (c >= 13 && c <= 16));
            tick();
            check("soft_level0", 32'(in_level[0]), 32'(!((c >= 5 && c < 9) || (c >= 17 && c < 21))));
            check("soft_sys",    32'(sys_reset_n), 32'((c < 5) || (c >= 37)));
        end

        io_in[3] = 1'b1;
        repeat (4) tick();
        io_in[3] = 1'b0;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("midrst_level3", 32'(in_level[3]), 32'h0);
        end
        repeat (8) tick();

        hold = 0;
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            if (hold == 0) begin
                io_in    = 6'($urandom);
                io_in[0] = ($urandom_range(0, 7) != 0);
                hold     = $urandom_range(1, 6);
            end
            hold--;
            if (n % 25 == 0) begin
                la_oenb[15:0]  = ~(16'($urandom) & 16'($urandom) & 16'($urandom));
                la_oenb[39:32] = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
            end
            la_data_in[15:0] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) la_data_in[39:32] = 8'($urandom);
            stat_in = 2'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/io_frontend_unit.md
IO_FRONTEND_UNIT -- requirements
Module: io_frontend_unit

Interface
REQ-001 Parameters SHALL be:
- NUM_OF_DRIVERS, default 10: driver output-enable channels.
- NUM_IN, default 6: pad inputs (0 reset_n, 1 latch_data, 2 control_trigger, 3 sclk, 4 mosi, 5 ss_n).
- NUM_OUT, default 2: pad outputs (0 update_cycle_complete, 1 miso).
- SYNC_STAGES, default 2 (range 2..4): synchronizer depth.
- FILTER_LEN, default 3 (range 1..15): number of consecutive samples needed to accept a level change.
- RESET_STRETCH, default 16: extra low cycles added to sys_reset_n.
- INPUT_RESET_VAL, default 6'b000001: reset value of the filtered levels.
- LA_OEB_BASE, default 0: first la_oenb/la_data_in bit used for oeb control.
- LA_DATA_BASE, default 32: first LA bit used for data override.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1: single clock.
- reset_n, in, 1: asynchronous, active-low reset.
- la_data_in, in, 128: logic-analyzer data.
- la_oenb, in, 128: logic-analyzer enables, active-low.
- io_in, in, NUM_IN: pad inputs.
- io_in_oeb, out, NUM_IN: input pad output-enables.
- stat_in, in, NUM_OUT: internal status to drive onto pads.
- io_out, out, NUM_OUT: pad outputs.
- io_out_oeb, out, NUM_OUT: output pad output-enables.
- io_driver_oeb, out, NUM_OF_DRIVERS: driver pad output-enables.
- in_level, out, NUM_IN: filtered input levels.
- in_rise, out, NUM_IN: one-cycle rising-edge pulses.
- in_fall, out, NUM_IN: one-cycle falling-edge pulses.
- sys_reset_n, out, 1: stretched system reset.
REQ-003 The LA map SHALL be:
- oeb bits: LA_OEB_BASE + [inputs, outputs, drivers] in that order.
- data bits: LA_DATA_BASE + [inputs, outputs].
- Every mapped index SHALL be below 128; an out-of-range parameter set is an elaboration error.

Function
REQ-004 Each pad-enable bit SHALL be registered: the LA bit when its la_oenb bit = 0, otherwise the default. Defaults: io_in_oeb = 1, io_out_oeb = 0, io_driver_oeb = 0. Latency is 1 cycle.
REQ-005 io_out[k] SHALL be registered: LA data when overridden, otherwise stat_in[k]. Latency is 1 cycle.
REQ-006 Raw input i SHALL be the LA data bit when overridden, otherwise io_in[i]. This selection SHALL happen before the synchronizer, so override switching is filtered like any other input edge.
REQ-007 Each raw input SHALL pass through a SYNC_STAGES flop chain.
REQ-008 Each input SHALL have a filter counter of width clog2(FILTER_LEN+1):
- If the synchronized sample equals in_level, the counter SHALL clear.
- Otherwise the counter SHALL increment.
- On the FILTER_LEN-th consecutive differing sample, in_level SHALL toggle and the counter SHALL clear.
REQ-009 A pad change held steady SHALL reach in_level exactly SYNC_STAGES+FILTER_LEN cycles after the clock edge that first samples it.
REQ-010 A pulse shorter than FILTER_LEN synchronized samples SHALL NOT change in_level. A sample that returns to in_level before the count completes SHALL restart the count.
REQ-011 in_rise[i] / in_fall[i] SHALL be registered and high for exactly the one cycle in which in_level[i] shows its new value 1 / 0. At most one of them SHALL be high per cycle.
REQ-012 sys_reset_n SHALL go low asynchronously when reset_n is low. It SHALL go low on the clock edge where in_level[0] becomes 0.
REQ-013 After both reset_n and in_level[0] are high, sys_reset_n SHALL stay low for exactly RESET_STRETCH further cycles, counted by a down-counter. A new in_level[0] low during the stretch SHALL reload the count.

Reset
REQ-014 While reset_n is low, the following SHALL hold:
- all synchronizer stages and in_level = INPUT_RESET_VAL;
- all counters = 0;
- in_rise = in_fall = 0;
- io_in_oeb = all 1; io_out_oeb = 0; io_driver_oeb = 0; io_out = 0;
- sys_reset_n = 0 and the stretch counter = RESET_STRETCH.
REQ-015 Reset release SHALL NOT produce rise/fall pulses. Reset asserted mid-filter SHALL discard the partial count.

Structure
REQ-016 The LA index offsets, default oeb values and input-index constants SHALL live in a shared package, io_frontend_pkg.
REQ-017 The synchronizer, filter and edge logic SHALL be one sub-module, input_filter_channel, instantiated NUM_IN times by generate. The oeb, output and stretch logic stay in the top level.

Verification
REQ-018 The bench (defaults) SHALL cover:
- Reset: reset_n = 0 -> in_level = 6'b000001, io_in_oeb = 6'h3F, io_out_oeb = 0, sys_reset_n = 0; after release, sys_reset_n rises at cycle 16.
- Step: io_in[1] 0->1 held -> in_level[1] = 1 at cycle 5, in_rise[1] high for cycle 5 only.
- Glitch: io_in[2] high for 2 cycles -> in_level[2] stays 0 and no pulses occur; a 3-cycle pulse toggles it.
- LA override:
  - la_oenb[33] = 0, la_data_in[33] = 1, io_in[1] = 0 -> in_level[1] = 1 after 5 cycles.
  - la_oenb[7] = 0, la_data_in[7] = 1 -> io_out_oeb[1] = 1 next cycle.
- Soft reset: io_in[0] low 4 cycles -> sys_reset_n falls with in_level[0], returns high 16 cycles after in_level[0] rises; re-lowering at stretch cycle 8 reloads the count to 16.
- Mid-filter reset: reset_n pulse during a count of 2 -> no in_level change after release.
